summ_bcd_display: RTL and testbench
===================================

# summ_bcd_display

Downstream display stage for the summator: it takes the 9-bit binary sum that drives the green LEDs and converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine. It drives one active-low 7-segment digit per BCD digit. A single `start` pulse launches a conversion; a `busy`/`done` handshake tells the controller when the new value is on the displays. The displayed value holds until the next completed conversion.

## Interface
- `WIDTH`, default 9: binary input width.
- `DIGITS`, default 3: number of BCD digits and segment displays. Constraint: 10^DIGITS > 2^WIDTH − 1; other settings are unsupported.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `bin` in WIDTH: binary value; captured on the edge that accepts `start`.
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: one-cycle pulse; new `bcd`/`seg` are valid in the same cycle.
- `bcd` out 4*DIGITS: registered result; digit i is at [4i+3:4i], with digit 0 the least significant.
- `seg` out 7*DIGITS: registered active-low segments; digit i is at [7i+6:7i], bit order gfedcba, bit 0 = a.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 loads shift register ← `bin` and scratch BCD ← 0.
  - Loads bit counter ← WIDTH and moves to SHIFT.
  - `start`=0 stays in IDLE.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3 (4-bit add, no carry between digits).
  - Then {scratch, shift register} shifts left by 1.
  - Counter decrements; when it reaches 0 after the shift, go to DONE.
- DONE:
  - `bcd` ← scratch and `seg` ← encode(scratch).
  - `done` pulses.
  - Return to IDLE.
- Segment encoding (hex, active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, blank→7F.
- `start` while `busy`=1 is ignored. It is not queued.
- `bin` changes after capture do not affect the conversion in progress.
- `bcd`/`seg` change only in DONE or on reset. There are no intermediate values on the displays.

## Timing
- `start` sampled at edge E0. SHIFT occupies edges E1…E_WIDTH. DONE is entered after edge E_WIDTH.
- `done`=1 and the new `bcd`/`seg` appear in the cycle following E_WIDTH+1.
- Latency from `start` edge to `done` is WIDTH+1 cycles (10 for the default).
- `busy` rises the cycle after E0 and falls together with the `done` pulse.
- Back-to-back: a `start` asserted during the `done` cycle is accepted, since the FSM is already in IDLE. Throughput is one conversion per WIDTH+2 cycles.
- Reset values:
  - FSM IDLE, `busy`=0, `done`=0, `bcd`=0.
  - `seg` = all digits "0" (40 each), or per Configuration.
- `rst` mid-conversion: abort on that edge. Reset values appear the next cycle and no `done` is issued.
- `rst` and `start` in the same cycle: reset wins and the request is dropped.

## Configuration
- `SUMM_LZ_BLANK_EN` defined: leading-zero blanking. Every digit above the most significant nonzero digit shows 7F. Digit 0 always shows its value, so 0 displays as a single "0". The same rule applies to the reset value of `seg`.
- Undefined: all digits are always shown, leading zeros included.
- `bcd` and all timing are identical in both builds.

## Test plan
- Reset: hold `rst` 2 cycles → `busy`=0, `done`=0, `bcd`=0x000.
  - Macro off: `seg`={40,40,40}.
  - Macro on: `seg`={7F,7F,40}.
- `bin`=510 (0x1FE), `start` pulse → `done` exactly 10 cycles later and `busy` high for 10 cycles.
  - Result: `bcd`=0x510, `seg`={12,79,40}.
- Range ends:
  - `bin`=0 → `bcd`=0x000.
  - `bin`=511 → `bcd`=0x511, `seg`={12,79,79}.
  - `bin`=99 → `bcd`=0x099.
- Ignored start: `start` with `bin`=255, then `start` with `bin`=7 three cycles later → exactly one `done`, with `bcd`=0x255.
  - A new `start` with `bin`=7 during the `done` cycle is accepted → `bcd`=0x007 ten cycles later.
- Reset mid-operation: `start` with `bin`=300, `rst` on the 4th cycle → no `done` pulse.
  - `bcd` returns to 0x000 the next cycle.
  - A following `start` with `bin`=300 yields 0x300.
- Blanking: `bin`=7.
  - Macro on: `seg`={7F,7F,78}.
  - Macro off: `seg`={40,40,78}.
  - `bcd`=0x007 in both builds.

Source files
------------

// File: rtl/summ_bcd_display.sv
// Binary-to-BCD display stage: sequential double-dabble conversion driving active-low 7-segment digits.
// Define SUMM_LZ_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module summ_bcd_display #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   adj;

  function automatic logic [6:0] encDigit(input logic [3:0] d);
    case (d)
      4'd0:    encDigit = 7'h40;
      4'd1:    encDigit = 7'h79;
      4'd2:    encDigit = 7'h24;
      4'd3:    encDigit = 7'h30;
      4'd4:    encDigit = 7'h19;
      4'd5:    encDigit = 7'h12;
      4'd6:    encDigit = 7'h02;
      4'd7:    encDigit = 7'h78;
      4'd8:    encDigit = 7'h00;
      4'd9:    encDigit = 7'h10;
      default: encDigit = 7'h7F;
    endcase
  endfunction

  // Walk from the top digit down so blanking stops at the first nonzero digit.
  function automatic logic [7*DIGITS-1:0] encAll(input logic [4*DIGITS-1:0] v);
    logic [7*DIGITS-1:0] s;
`ifdef SUMM_LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      s[7*i +: 7] = encDigit(v[4*i +: 4]);
`ifdef SUMM_LZ_BLANK_EN
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) s[7*i +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    seg_d     = seg_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        seg_d   = encAll(scratch_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Displays only ever change from DONE or reset, so no partial values leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      seg_q     <= encAll('0);
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_summ_bcd_display.sv
// Directed self-checking bench for summ_bcd_display; expected values are hand-computed.
// Honours SUMM_LZ_BLANK_EN for the expected segment patterns.
module tb_summ_bcd_display;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [20:0] seg;

  int testsRun;
  int testsFailed;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S9 = 7'h10;
`ifdef SUMM_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  summ_bcd_display #(.WIDTH(9), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] segOf(input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    return {d2, d1, d0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse start for one cycle; returns on the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [8:0] value);
    @(negedge clk);
    start = 1'b1;
    bin   = value;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'(cycles), 32'd10);
  endtask

  task automatic convert(input string tag, input logic [8:0] value, input logic [11:0] expBcd,
                         input logic [20:0] expSeg);
    int cyc, bcyc;
    applyStimulus(value);
    waitDone(tag, cyc, bcyc);
    checkOutput({tag, "_bcd"}, 32'(bcd), 32'(expBcd));
    checkOutput({tag, "_seg"}, 32'(seg), 32'(expSeg));
  endtask

  initial begin
    int cyc, bcyc, doneCount;
    logic [11:0] firstBcd;
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    start = 1'b0;
    bin = '0;
    firstBcd = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_bcd", 32'(bcd), 32'h000);
    checkOutput("reset_seg", 32'(seg), 32'(segOf(LZ, LZ, S0)));
    rst = 1'b0;

    applyStimulus(9'd510);
    waitDone("lat510", cyc, bcyc);
    checkOutput("lat510_cycles", 32'(cyc), 32'd10);
    checkOutput("lat510_busyCycles", 32'(bcyc), 32'd10);
    checkOutput("lat510_busyAtDone", 32'(busy), 32'd0);
    checkOutput("lat510_bcd", 32'(bcd), 32'h510);
    checkOutput("lat510_seg", 32'(seg), 32'(segOf(S5, S1, S0)));
    @(negedge clk);
    checkOutput("lat510_donePulse", 32'(done), 32'd0);

    convert("zero", 9'd0, 12'h000, segOf(LZ, LZ, S0));
    convert("max511", 9'd511, 12'h511, segOf(S5, S1, S1));
    convert("v99", 9'd99, 12'h099, segOf(LZ, S9, S9));
    convert("v7", 9'd7, 12'h007, segOf(LZ, LZ, S7));

    // Second start arrives while busy and must be dropped; a start during done is accepted.
    applyStimulus(9'd255);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin = 9'd7;
    @(negedge clk);
    start = 1'b0;
    bin = 9'd0;
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        doneCount++;
        firstBcd = bcd;
        start = 1'b1;
        bin = 9'd7;
      end
    end
    start = 1'b0;
    checkOutput("ignored_doneCount", 32'(doneCount), 32'd1);
    checkOutput("ignored_bcd", 32'(firstBcd), 32'h255);
    waitDone("b2b", cyc, bcyc);
    checkOutput("b2b_bcd", 32'(bcd), 32'h007);

    // Reset in the 4th cycle of a conversion aborts it without a done pulse.
    applyStimulus(9'd300);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_bcd", 32'(bcd), 32'h000);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort_noDone", 32'(doneCount), 32'd0);
    convert("v300", 9'd300, 12'h300, segOf(S3, S0, S0));

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    bin = 9'd123;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rstStart_busy", 32'(busy), 32'd0);

    convert("v255", 9'd255, 12'h255, segOf(S2, S5, S5));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
